// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the memory-side blocks.
//   XLEN : datapath width in bits (byte lanes = XLEN/8)
package core_config_pkg;
   localparam int unsigned XLEN = 32;
endpackage

// File: rtl/dmem_responder.sv
// dmem_responder
//   Single-port data memory slave for a two-cycle request handshake.
//   The initiator holds mem_req high for two cycles. The first clk edge that
//   sees mem_req high in IDLE performs exactly one access and registers the
//   response, which is then held until mem_req drops.
//
//   Optional build macro:
//     DMEM_ALIGN_CHECK_EN - also flag misaligned addresses and byte-enable
//                           patterns that are not a legal byte, half or word.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   mem_addr    in   XLEN    byte address of the request
//   mem_byteen  in   XLEN/8  byte lane enables (writes only)
//   mem_we      in   1 = write, 0 = read
//   mem_req     in   request strobe, held for two cycles per access
//   mem_wdata   in   XLEN    write data, already lane-positioned
//   mem_rdata   out  XLEN    read data (full word), 0 outside a read response
//   mem_err     out  access error, 0 outside a response
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for mem_req; outputs forced to zero
//   RESP  | access done, response held until mem_req drops
module dmem_responder
   import core_config_pkg::*;
#(
   parameter int unsigned     DEPTH     = 1024,
   parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [XLEN-1:0]   mem_addr,
   input  logic [XLEN/8-1:0] mem_byteen,
   input  logic              mem_we,
   input  logic              mem_req,
   input  logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN-1:0]   mem_rdata,
   output logic              mem_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NB = XLEN / 8;
   localparam int unsigned WW = XLEN - 2;
   localparam logic [WW-1:0] DEPTH_W = WW'(DEPTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   logic [0:0]      r_state;
   logic [XLEN-1:0] r_rdata;
   logic            r_err;
   logic [XLEN-1:0] r_mem [DEPTH];

   logic [WW-1:0]   w_word;
   logic [AW-1:0]   w_idx;
   logic            w_below;
   logic            w_range_err;
   logic            w_err;
   logic            w_access;
   logic            w_wr_en;

   // BASE_ADDR is word-aligned, so the word offset can be formed from the
   // upper address bits alone. A wrap below BASE_ADDR is caught by w_below,
   // which compares the full byte address.
   assign w_word      = mem_addr[XLEN-1:2] - BASE_ADDR[XLEN-1:2];
   assign w_idx       = w_word[AW-1:0];
   assign w_below     = (mem_addr < BASE_ADDR);
   assign w_range_err = w_below || (w_word >= DEPTH_W);

`ifdef DMEM_ALIGN_CHECK_EN
   logic w_be_legal;
   logic w_align_err;

   always_comb begin
      w_be_legal = 1'b0;
      case (mem_byteen)
         NB'(4'b0001), NB'(4'b0010), NB'(4'b0100), NB'(4'b1000),
         NB'(4'b0011), NB'(4'b1100), NB'(4'b1111): w_be_legal = 1'b1;
         default:                                  w_be_legal = 1'b0;
      endcase
   end

   assign w_align_err = (mem_addr[1:0] != 2'b00) || !w_be_legal;
   assign w_err       = w_range_err || w_align_err;
`else
   assign w_err       = w_range_err;
`endif

   // rst_n gates the access so a request seen while reset is held cannot
   // sneak a write into the (unreset) storage array.
   assign w_access = (r_state == ST_IDLE) && mem_req && rst_n;
   assign w_wr_en  = w_access && mem_we && !w_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (mem_req) begin
                  r_state <= ST_RESP;
                  r_err   <= w_err;
                  r_rdata <= (!mem_we && !w_err) ? r_mem[w_idx] : '0;
               end
            end
            ST_RESP: begin
               if (!mem_req) begin
                  r_state <= ST_IDLE;
                  r_rdata <= '0;
                  r_err   <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_rdata <= '0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_byteen[i]) begin
               r_mem[w_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   assign mem_rdata = r_rdata;
   assign mem_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN_ON = 1'b1;
`else
   localparam bit ALIGN_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [3:0]  mem_byteen = '0;
   logic        mem_we = 1'b0;
   logic        mem_req = 1'b0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        mem_err;

   int n_checks = 0;
   int n_errors = 0;

   // expected outputs, maintained by the transaction-level model
   logic [31:0] exp_rdata = '0;
   logic        exp_err   = 1'b0;
   bit          exp_known = 1'b1;

   logic [31:0] mdl_mem [int unsigned];
   logic [31:0] last_rdata;
   logic        last_err;

   dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
      .mem_we(mem_we), .mem_req(mem_req), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic mdl_err(input logic [31:0] a, input logic [3:0] be);
      logic e;
      e = (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
      if (ALIGN_ON && ((a[1:0] != 2'b00) ||
          !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})))
         e = 1'b1;
      return e;
   endfunction

   function automatic int unsigned mdl_idx(input logic [31:0] a);
      return (a - BASE) >> 2;
   endfunction

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (exp_known) chk("rdata", mem_rdata, exp_rdata);
      chk("err", {31'b0, mem_err}, {31'b0, exp_err});
   end

   // One complete transaction: req high for ncyc cycles; wdata switches to
   // wdata2 after the first req cycle.
   task automatic access(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input int ncyc, input logic [31:0] wd2);
      logic        e;
      int unsigned k;
      logic [31:0] resp;
      bit          known;
      e = mdl_err(a, be);
      k = mdl_idx(a);
      resp  = '0;
      known = 1'b1;
      if (!we && !e) begin
         if (mdl_mem.exists(k)) resp = mdl_mem[k];
         else known = 1'b0;
      end
      @(posedge clk); #1;
      mem_addr = a; mem_we = we; mem_byteen = be; mem_wdata = wd; mem_req = 1'b1;
      @(posedge clk); #1;
      if (we && !e) begin
         logic [31:0] old;
         old = mdl_mem.exists(k) ? mdl_mem[k] : 32'h0;
         for (int i = 0; i < 4; i++) if (be[i]) old[8*i +: 8] = wd[8*i +: 8];
         mdl_mem[k] = old;
      end
      exp_rdata = resp; exp_err = e; exp_known = known;
      mem_wdata = wd2;
      @(negedge clk);
      last_rdata = mem_rdata; last_err = mem_err;
      repeat (ncyc - 1) @(posedge clk);
      #1 mem_req = 1'b0;
      @(posedge clk); #1;
      exp_rdata = '0; exp_err = 1'b0; exp_known = 1'b1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      access(a, 1'b1, be, wd, 2, wd);
   endtask

   task automatic rd(input logic [31:0] a);
      access(a, 1'b0, 4'b1111, 32'h0, 2, 32'h0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      chk("reset_rdata", mem_rdata, 32'h0);
      chk("reset_err", {31'b0, mem_err}, 32'h0);
      #2 rst_n = 1'b1;

      // write then read
      wr(32'h10, 4'b1111, 32'hDEADBEEF);
      chk("sw_err", {31'b0, last_err}, 32'h0);
      chk("sw_rdata_zero", last_rdata, 32'h0);
      rd(32'h10);
      chk("lw_10", last_rdata, 32'hDEADBEEF);
      chk("lw_10_err", {31'b0, last_err}, 32'h0);
      chk("mdl_10", mdl_mem[4], 32'hDEADBEEF);

      // partial byte write
      wr(32'h20, 4'b1111, 32'h11223344);
      wr(32'h20, 4'b0100, 32'h00AA0000);
      rd(32'h20);
      chk("sb_20", last_rdata, 32'h11AA3344);
      chk("mdl_20", mdl_mem[8], 32'h11AA3344);

      // range error and boundary
      wr(32'h0, 4'b1111, 32'hCAFEF00D);
      wr(32'h1000, 4'b1111, 32'h12345678);
      chk("range_err", {31'b0, last_err}, 32'h1);
      rd(32'h0);
      chk("lw_0", last_rdata, 32'hCAFEF00D);
      rd(32'h1000);
      chk("lw_oor_err", {31'b0, last_err}, 32'h1);
      chk("lw_oor_rdata", last_rdata, 32'h0);
      wr(32'hFFC, 4'b1111, 32'h55AA55AA);
      chk("last_word_err", {31'b0, last_err}, 32'h0);
      rd(32'hFFC);
      chk("lw_ffc", last_rdata, 32'h55AA55AA);

      // held request: one write only, data captured at first sample
      access(32'h8, 1'b1, 4'b1111, 32'h1, 5, 32'h2);
      rd(32'h8);
      chk("held_8", last_rdata, 32'h1);

      // zero byte enables
      wr(32'h10, 4'b0000, 32'h0);
      chk("be0_err", {31'b0, last_err}, ALIGN_ON ? 32'h1 : 32'h0);
      rd(32'h10);
      chk("be0_keep", last_rdata, 32'hDEADBEEF);

      // illegal lane pattern
      wr(32'h30, 4'b1111, 32'h11223344);
      wr(32'h30, 4'b0110, 32'h00BBCC00);
      chk("be0110_err", {31'b0, last_err}, ALIGN_ON ? 32'h1 : 32'h0);
      rd(32'h30);
      chk("be0110_data", last_rdata, ALIGN_ON ? 32'h11223344 : 32'h11BBCC44);

      // misaligned read
      rd(32'h11);
      chk("lw_11_err", {31'b0, last_err}, ALIGN_ON ? 32'h1 : 32'h0);
      chk("lw_11_data", last_rdata, ALIGN_ON ? 32'h0 : 32'hDEADBEEF);

      // reset during the response cycle
      @(posedge clk); #1;
      mem_addr = 32'h10; mem_we = 1'b0; mem_byteen = 4'b1111; mem_req = 1'b1;
      @(posedge clk); #1;
      exp_rdata = 32'hDEADBEEF; exp_err = 1'b0;
      #2 rst_n = 1'b0;
      exp_rdata = '0; exp_err = 1'b0;
      #1;
      chk("rst_resp_rdata", mem_rdata, 32'h0);
      chk("rst_resp_err", {31'b0, mem_err}, 32'h0);
      mem_req = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      rd(32'h10);
      chk("post_rst_lw", last_rdata, 32'hDEADBEEF);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH SHALL be: default 1024, number of XLEN-bit storage words; power of two, at least 4.
REQ-002 Parameter BASE_ADDR SHALL be: default 32'h0000_0000, byte address of word 0; word-aligned.
REQ-003 Ports SHALL be:
- clk  in  1  clock. One clock domain; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  in  XLEN  byte address of the request.
- mem_byteen  in  XLEN/8  byte lane enables.
- mem_we  in  1  1 = write, 0 = read.
- mem_req  in  1  request strobe, held high by the initiator for 2 cycles per access.
- mem_wdata  in  XLEN  write data, already lane-positioned.
- mem_rdata  out  XLEN  read data, full word.
- mem_err  out  1  access error.
REQ-004 XLEN SHALL be taken from core_config_pkg.

Function
REQ-005 Storage SHALL be DEPTH words of XLEN bits, indexed by (mem_addr - BASE_ADDR) >> 2.
REQ-006 The FSM SHALL have two states: IDLE and RESP.
REQ-007 In IDLE, at a clk edge with mem_req=1, the block SHALL perform exactly one access, register the response, and enter RESP.
REQ-008 In RESP, the FSM SHALL stay in RESP while mem_req=1 and SHALL return to IDLE at the first edge with mem_req=0.
- No second access is performed while in RESP.
- A new access requires at least one low cycle on mem_req.
REQ-009 Latency: mem_rdata and mem_err SHALL be valid for the whole cycle after the sampling edge, which is the initiator's second req cycle, and SHALL stay stable for as long as the FSM is in RESP.
REQ-010 In IDLE, mem_rdata SHALL be 0 and mem_err SHALL be 0.
REQ-011 Read (mem_we=0, no error): mem_rdata SHALL be the full stored word regardless of mem_byteen; lane selection and extension are the initiator's job.
REQ-012 Write (mem_we=1, no error): only the bytes with mem_byteen[i]=1 SHALL be updated from mem_wdata[8i+7:8i]; all other bytes SHALL keep their value; mem_rdata SHALL be 0 in RESP.
REQ-013 An out-of-range access SHALL set mem_err=1. Out of range means mem_addr < BASE_ADDR or word index >= DEPTH.
REQ-014 On any error, a write SHALL be suppressed (storage unchanged) and mem_rdata SHALL be 0.
REQ-015 mem_byteen=0 with mem_we=1 and no error SHALL leave storage unchanged with mem_err=0.
REQ-016 A write followed by a read of the same word in the next transaction SHALL return the written data; there is no stale-data window.
REQ-017 Address arithmetic SHALL be unsigned XLEN-bit; a subtraction that wraps below BASE_ADDR SHALL be treated as out of range.

Reset
REQ-018 While rst_n=0: state SHALL be IDLE, mem_rdata SHALL be 0, and mem_err SHALL be 0.
REQ-019 Storage contents SHALL NOT be reset.
REQ-020 A write committed at a sampling edge before reset asserts SHALL persist.
REQ-021 Reset asserted in RESP SHALL abort the response; after release, the block SHALL wait in IDLE for a new mem_req.

Configuration
REQ-022 Macro DMEM_ALIGN_CHECK_EN defined: mem_err SHALL also be 1 in either of these cases:
- mem_addr[1:0] != 0;
- mem_byteen is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111 (0000 counts as illegal under this macro).
REQ-023 Macro DMEM_ALIGN_CHECK_EN undefined: only the range check SHALL set mem_err; mem_addr[1:0] SHALL be ignored and mem_byteen applied raw.

Verification
REQ-024 Write then read: SW addr 0x10, wdata 0xDEADBEEF, byteen 1111; then LW 0x10 -> mem_rdata=0xDEADBEEF in the 2nd req cycle, mem_err=0.
REQ-025 Partial write: word 0x20 = 0x11223344; SB byteen 0100, wdata 0x00AA0000 -> read 0x20 returns 0x11AA3344.
REQ-026 Range error: DEPTH=1024, SW addr 0x1000 -> mem_err=1 in RESP, no storage change; read 0x0 is unaffected.
REQ-027 Held req: mem_req high for 5 cycles on a write of 0x1 to 0x8, with wdata changed to 0x2 after cycle 1 -> exactly one write; 0x8 reads 0x1.
REQ-028 Reset in RESP: rst_n low during the 2nd req cycle of a read -> mem_rdata=0 and mem_err=0 immediately; the next read returns the stored value.
REQ-029 With DMEM_ALIGN_CHECK_EN: byteen 0110 write -> mem_err=1, storage unchanged. Without the macro: the same write updates bytes 1 and 2, mem_err=0.
